// File: rtl/fadd_pre_aligner_pkg.sv
// Shared types, widths and the binary32 unpack helper for the FP add/sub front end.
// The unpack helper optionally flushes denormals to signed zero (see FADD_PRE_ALIGN_FLUSH_DENORM_EN in the top).
package fadd_pkg;

  localparam int EXP_W     = 8;
  localparam int MAN_W     = 23;
  localparam int GRS_W     = 3;
  localparam int ALIGN_CAP = 26;
  localparam int SIG_W     = MAN_W + 1;
  localparam int EXT_W     = SIG_W + GRS_W;
  localparam int SHAMT_W   = 5;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] eff_exp;
    logic [SIG_W-1:0] sig;
    logic             is_nan;
    logic             is_inf;
    logic             is_zero;
    logic             is_denorm;
  } unpacked_op_t;

  typedef struct packed {
    logic               eff_sub;
    logic               sign;
    logic [EXP_W-1:0]   exp_big;
    logic [SIG_W-1:0]   sig_big;
    logic [SIG_W-1:0]   sig_small;
    logic [SHAMT_W-1:0] diff;
    logic               nan;
    logic               inf;
    logic               dend;
  } s1_payload_t;

  typedef struct packed {
    logic [EXP_W-1:0] exponent;
    logic [SIG_W:0]   significand;
    logic [GRS_W-1:0] guard;
    logic             op_sign;
    logic             sign;
    logic             dend;
    logic             nan;
    logic             inf;
  } s2_result_t;

  // A flushed denormal comes out as a true zero, so is_denorm is never set for it.
  function automatic unpacked_op_t unpack(input logic [31:0] op, input logic flush);
    unpacked_op_t     u;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = op[30:23];
    f = op[22:0];
    if (flush && (e == '0)) f = '0;
    u.sign      = op[31];
    u.eff_exp   = (e == '0) ? EXP_W'(1) : e;
    u.sig       = {(e != '0), f};
    u.is_nan    = (&e) && (f != '0);
    u.is_inf    = (&e) && (f == '0);
    u.is_zero   = (e == '0) && (f == '0);
    u.is_denorm = (e == '0) && (f != '0);
    return u;
  endfunction

endpackage

// File: rtl/fadd_pre_aligner_if.sv
// Operand-in / result-out valid-ready bundle of the FP add pre-aligner.
interface fadd_pre_aligner_if #(parameter int TAG_W = 4);

  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      op_a_i;
  logic [31:0]      op_b_i;
  logic             op_sub_i;
  logic [TAG_W-1:0] tag_i;

  logic             out_valid_o;
  logic             out_ready_i;
  logic [7:0]       raw_exponent_o;
  logic [24:0]      raw_significand_o;
  logic [2:0]       guard_o;
  logic             operation_sign_o;
  logic             sign_o;
  logic             dend_flag_o;
  logic             nan_o;
  logic             inf_o;
  logic [TAG_W-1:0] tag_o;

  modport slave (
    input  in_valid_i, op_a_i, op_b_i, op_sub_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, raw_exponent_o, raw_significand_o, guard_o,
           operation_sign_o, sign_o, dend_flag_o, nan_o, inf_o, tag_o
  );

  modport master (
    output in_valid_i, op_a_i, op_b_i, op_sub_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, raw_exponent_o, raw_significand_o, guard_o,
           operation_sign_o, sign_o, dend_flag_o, nan_o, inf_o, tag_o
  );

endinterface

// File: rtl/fadd_pre_aligner_align_shifter.sv
// 27-bit logical right shifter; every bit shifted out is ORed into the result LSB (sticky).
module fadd_align_shifter
  import fadd_pkg::*;
(
  input  logic [EXT_W-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [EXT_W-1:0]   data_o
);

  logic [EXT_W-1:0] shifted;
  logic [EXT_W-1:0] lost_mask;
  logic             sticky;

  always_comb begin
    shifted   = data_i >> shamt_i;
    lost_mask = ~({EXT_W{1'b1}} << shamt_i);
    sticky    = |(data_i & lost_mask);
    data_o    = {shifted[EXT_W-1:1], shifted[0] | sticky};
  end

endmodule

// File: rtl/fadd_pre_aligner.sv
// Binary32 add/sub front end: unpack/compare/swap (stage 1), align + raw add/sub (stage 2).
// Define FADD_PRE_ALIGN_FLUSH_DENORM_EN to flush denormal inputs to signed zero (dend_flag_o then reads 0).
module fadd_pre_aligner
  import fadd_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  fadd_pre_aligner_if.slave bus
);

`ifdef FADD_PRE_ALIGN_FLUSH_DENORM_EN
  localparam logic FLUSH_DENORM = 1'b1;
`else
  localparam logic FLUSH_DENORM = 1'b0;
`endif

  logic             s1_valid_q;
  logic             s2_valid_q;
  logic             s1_advance;
  logic             s2_advance;
  s1_payload_t      s1_d, s1_q;
  s2_result_t       s2_d, s2_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;

  unpacked_op_t     ua, ub;
  logic [30:0]      mag_a, mag_b;
  logic             swap;
  logic             eff_sub;
  logic [EXP_W-1:0] exp_small;
  logic [EXP_W-1:0] diff_full;

  logic [EXT_W-1:0] big_ext, small_pre, small_ext;
  logic [EXT_W:0]   sum;
  logic [EXT_W-1:0] dif;

  assign s2_advance     = ~s2_valid_q | bus.out_ready_i;
  assign s1_advance     = ~s1_valid_q | s2_advance;
  assign bus.in_ready_o = rst_i | s1_advance;

  // Magnitude key uses the raw exponent field so a denormal always orders below any normal.
  always_comb begin
    ua        = unpack(bus.op_a_i, FLUSH_DENORM);
    ub        = unpack(bus.op_b_i, FLUSH_DENORM);
    mag_a     = {(ua.is_zero | ua.is_denorm) ? 8'h00 : ua.eff_exp, ua.sig[MAN_W-1:0]};
    mag_b     = {(ub.is_zero | ub.is_denorm) ? 8'h00 : ub.eff_exp, ub.sig[MAN_W-1:0]};
    swap      = mag_b > mag_a;
    eff_sub   = bus.op_sub_i ^ ua.sign ^ ub.sign;
    exp_small = swap ? ua.eff_exp : ub.eff_exp;

    s1_d           = '0;
    s1_d.eff_sub   = eff_sub;
    s1_d.exp_big   = swap ? ub.eff_exp : ua.eff_exp;
    s1_d.sig_big   = swap ? ub.sig : ua.sig;
    s1_d.sig_small = swap ? ua.sig : ub.sig;
    diff_full      = s1_d.exp_big - exp_small;
    s1_d.diff      = (diff_full > EXP_W'(ALIGN_CAP)) ? SHAMT_W'(ALIGN_CAP) : diff_full[SHAMT_W-1:0];

    if (eff_sub && (mag_a == mag_b)) s1_d.sign = 1'b0;
    else if (swap)                   s1_d.sign = ub.sign ^ bus.op_sub_i;
    else                             s1_d.sign = ua.sign;

    s1_d.nan = ua.is_nan | ub.is_nan | (ua.is_inf & ub.is_inf & eff_sub);
    s1_d.inf = (ua.is_inf | ub.is_inf) & ~s1_d.nan;
`ifdef FADD_PRE_ALIGN_FLUSH_DENORM_EN
    s1_d.dend = 1'b0;
`else
    s1_d.dend = ua.is_denorm & ub.is_denorm;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s1_tag_q   <= '0;
    end else if (s1_advance) begin
      s1_valid_q <= bus.in_valid_i;
      if (bus.in_valid_i) begin
        s1_q     <= s1_d;
        s1_tag_q <= bus.tag_i;
      end
    end
  end

  fadd_align_shifter u_align (
    .data_i  (small_pre),
    .shamt_i (s1_q.diff),
    .data_o  (small_ext)
  );

  // Subtraction never goes negative because the swap put the larger magnitude on top.
  always_comb begin
    big_ext   = {s1_q.sig_big, {GRS_W{1'b0}}};
    small_pre = {s1_q.sig_small, {GRS_W{1'b0}}};
    sum       = {1'b0, big_ext} + {1'b0, small_ext};
    dif       = big_ext - small_ext;

    s2_d          = '0;
    s2_d.exponent = s1_q.exp_big;
    s2_d.op_sign  = ~s1_q.eff_sub;
    s2_d.sign     = s1_q.sign;
    s2_d.dend     = s1_q.dend;
    s2_d.nan      = s1_q.nan;
    s2_d.inf      = s1_q.inf;
    if (s1_q.eff_sub) begin
      s2_d.significand = {1'b0, dif[EXT_W-1:GRS_W]};
      s2_d.guard       = dif[GRS_W-1:0];
    end else begin
      s2_d.significand = sum[EXT_W:GRS_W];
      s2_d.guard       = sum[GRS_W-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
      s2_tag_q   <= '0;
    end else if (s2_advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_q     <= s2_d;
        s2_tag_q <= s1_tag_q;
      end
    end
  end

  assign bus.out_valid_o       = s2_valid_q;
  assign bus.raw_exponent_o    = s2_q.exponent;
  assign bus.raw_significand_o = s2_q.significand;
  assign bus.guard_o           = s2_q.guard;
  assign bus.operation_sign_o  = s2_q.op_sign;
  assign bus.sign_o            = s2_q.sign;
  assign bus.dend_flag_o       = s2_q.dend;
  assign bus.nan_o             = s2_q.nan;
  assign bus.inf_o             = s2_q.inf;
  assign bus.tag_o             = s2_tag_q;

endmodule

// File: tb/tb_fadd_pre_aligner.sv
// Directed, table-driven bench for fadd_pre_aligner plus stall / ordering / mid-stream reset sequences.
// Honours FADD_PRE_ALIGN_FLUSH_DENORM_EN for the denormal vector.
module tb_fadd_pre_aligner;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fadd_pre_aligner_if #(.TAG_W(4)) bus();

  fadd_pre_aligner #(.TAG_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [3:0]  tag;
    logic [7:0]  exp;
    logic [24:0] sig;
    logic [2:0]  grs;
    logic        opSign;
    logic        sign;
    logic        nan;
    logic        inf;
    logic        dend;
  } vec_t;

  vec_t vecs[11];
  int   errors = 0;
  int   checks = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int waitCyc;
    int lat;
    bus.op_a_i     = v.a;
    bus.op_b_i     = v.b;
    bus.op_sub_i   = v.sub;
    bus.tag_i      = v.tag;
    bus.in_valid_i = 1'b1;
    #1;
    waitCyc = 0;
    while (!bus.in_ready_o && waitCyc < 20) begin
      @(posedge clk); #1;
      waitCyc++;
    end
    checkOutput($sformatf("v%0d.accept", idx), 32'(bus.in_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    lat = 1;
    while (!bus.out_valid_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput($sformatf("v%0d.latency", idx), 32'(lat), 32'd2);
    checkOutput($sformatf("v%0d.exp", idx), 32'(bus.raw_exponent_o), 32'(v.exp));
    checkOutput($sformatf("v%0d.sig", idx), 32'(bus.raw_significand_o), 32'(v.sig));
    checkOutput($sformatf("v%0d.grs", idx), 32'(bus.guard_o), 32'(v.grs));
    checkOutput($sformatf("v%0d.opsign", idx), 32'(bus.operation_sign_o), 32'(v.opSign));
    checkOutput($sformatf("v%0d.sign", idx), 32'(bus.sign_o), 32'(v.sign));
    checkOutput($sformatf("v%0d.nan", idx), 32'(bus.nan_o), 32'(v.nan));
    checkOutput($sformatf("v%0d.inf", idx), 32'(bus.inf_o), 32'(v.inf));
    checkOutput($sformatf("v%0d.dend", idx), 32'(bus.dend_flag_o), 32'(v.dend));
    checkOutput($sformatf("v%0d.tag", idx), 32'(bus.tag_o), 32'(v.tag));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] got[$];
    logic       acc;
    int         seen;

    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 4'd1,  8'h80, 25'h0C00000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 4'd2,  8'h7F, 25'h0000000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h3F800000, 32'h30800000, 1'b0, 4'd3,  8'h7F, 25'h0800000, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef FADD_PRE_ALIGN_FLUSH_DENORM_EN
    vecs[3]  = '{32'h00400000, 32'h00400000, 1'b0, 4'd4,  8'h01, 25'h0000000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    vecs[3]  = '{32'h00400000, 32'h00400000, 1'b0, 4'd4,  8'h01, 25'h0800000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    vecs[4]  = '{32'h7F800000, 32'h7F800000, 1'b1, 4'd5,  8'hFF, 25'h0000000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{32'h7F800000, 32'h3F800000, 1'b0, 4'd6,  8'hFF, 25'h0800000, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{32'h40000000, 32'h3F800000, 1'b1, 4'd7,  8'h80, 25'h0400000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h3F800000, 32'h40000000, 1'b1, 4'd8,  8'h80, 25'h0400000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h3F800000, 32'h3B800001, 1'b0, 4'd9,  8'h7F, 25'h0808000, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'hBF800000, 32'hBF800000, 1'b0, 4'd10, 8'h7F, 25'h1000000, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h7FC00000, 32'h3F800000, 1'b0, 4'd11, 8'hFF, 25'h0C00000, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    bus.in_valid_i  = 1'b0;
    bus.op_a_i      = '0;
    bus.op_b_i      = '0;
    bus.op_sub_i    = 1'b0;
    bus.tag_i       = '0;
    bus.out_ready_i = 1'b1;
    rst             = 1'b1;

    @(posedge clk); @(posedge clk); #1;
    checkOutput("reset.in_ready", 32'(bus.in_ready_o), 32'd1);
    checkOutput("reset.out_valid", 32'(bus.out_valid_o), 32'd0);
    checkOutput("reset.sig", 32'(bus.raw_significand_o), 32'd0);
    checkOutput("reset.exp", 32'(bus.raw_exponent_o), 32'd0);
    checkOutput("reset.tag", 32'(bus.tag_o), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) applyStimulus(i, vecs[i]);
    @(posedge clk); #1;

    // Back-to-back with the sink stalled: two accepts fill the pipe, then hold.
    bus.out_ready_i = 1'b0;
    bus.op_a_i      = vecs[0].a;
    bus.op_b_i      = vecs[0].b;
    bus.op_sub_i    = vecs[0].sub;
    bus.tag_i       = 4'd1;
    bus.in_valid_i  = 1'b1;
    #1;
    checkOutput("stall.ready0", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.tag_i = 4'd2;
    checkOutput("stall.ready1", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk); #1;
    bus.tag_i = 4'd3;
    checkOutput("stall.ready2", 32'(bus.in_ready_o), 32'd0);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("hold%0d.valid", c), 32'(bus.out_valid_o), 32'd1);
      checkOutput($sformatf("hold%0d.tag", c), 32'(bus.tag_o), 32'd1);
      checkOutput($sformatf("hold%0d.sig", c), 32'(bus.raw_significand_o), 32'h0C00000);
      checkOutput($sformatf("hold%0d.ready", c), 32'(bus.in_ready_o), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready_i = 1'b1;
    #1;
    checkOutput("stall.combo_ready", 32'(bus.in_ready_o), 32'd1);
    for (int c = 0; c < 12; c++) begin
      if (bus.out_valid_o && bus.out_ready_i) got.push_back(bus.tag_o);
      acc = bus.in_valid_i && bus.in_ready_o;
      @(posedge clk); #1;
      if (acc) bus.in_valid_i = 1'b0;
    end
    checkOutput("drain.count", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("drain.tag%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hF, 32'(i + 1));

    // Fill the stalled pipe again, then reset it mid-stream.
    bus.out_ready_i = 1'b0;
    bus.tag_i       = 4'd4;
    bus.in_valid_i  = 1'b1;
    @(posedge clk); #1;
    bus.tag_i = 4'd5;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    checkOutput("midrst.pre_valid", 32'(bus.out_valid_o), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst.in_ready", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk); #1;
    checkOutput("midrst.out_valid", 32'(bus.out_valid_o), 32'd0);
    checkOutput("midrst.sig", 32'(bus.raw_significand_o), 32'd0);
    checkOutput("midrst.tag", 32'(bus.tag_o), 32'd0);
    rst             = 1'b0;
    bus.out_ready_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (bus.out_valid_o) seen++;
    end
    checkOutput("midrst.no_ghost", 32'(seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
